hier_include_nested_credit_arb: RTL and testbench

//   Round-robin arbiter sharing the nested-top buffer pool between NUM_REQ requesters.
//   The pool holds YET_ANOTHER_SIZE entries, tracked by a credit counter.

---
 rtl/hier_include_nested_credit_arb_pkg.sv | 16 +
 rtl/hier_include_nested_credit_arb_if.sv | 29 ++
 rtl/hier_include_nested_credit_arb_rr_pick.sv | 43 ++++
 rtl/hier_include_nested_credit_arb.sv | 92 +++++++++
 tb/tb_hier_include_nested_credit_arb.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/hier_include_nested_credit_arb_pkg.sv
// Shared constants and types for the credit-based round-robin arbiter in front of
// the nested-top buffer pool.
package hierIncludeNestedTop_package;

  localparam int YET_ANOTHER_SIZE = 8;
  localparam int POOL_SIZE        = YET_ANOTHER_SIZE;
  localparam int NUM_REQ_DEF      = 4;
  localparam int ID_W_DEF         = $clog2(NUM_REQ_DEF);
  localparam int CREDIT_W         = $clog2(POOL_SIZE + 1);

  typedef enum logic {IDLE, HOLD} arbStateT;

  typedef logic [ID_W_DEF-1:0] reqIdT;
  typedef logic [CREDIT_W-1:0] creditT;

endpackage

// File: rtl/hier_include_nested_credit_arb_if.sv
// Requester/grant/credit-release bundle between the front-ends, the arbiter and the
// shared buffer. The master side is the arbiter.
interface hier_include_nested_credit_arb_if
  import hierIncludeNestedTop_package::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic               out_valid;
  logic               out_ready;
  logic [IDW-1:0]     out_id;
  logic               rel_valid;
  creditT             credits;
  logic               err_overflow;

  modport master (
    input  req_valid, out_ready, rel_valid,
    output req_ready, out_valid, out_id, credits, err_overflow
  );

  modport slave (
    output req_valid, out_ready, rel_valid,
    input  req_ready, out_valid, out_id, credits, err_overflow
  );

endinterface

// File: rtl/hier_include_nested_credit_arb_rr_pick.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping
// modulo NUM_REQ.
module hier_include_rr_pick
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [IDW-1:0]     win_idx,
  output logic               win_any
);

  logic [IDW-1:0] cand [NUM_REQ];

  // cand[gi] is the requester visited gi steps after rr_ptr.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [IDW:0] sum;
      logic [IDW:0] wrapped;
      assign sum     = {1'b0, rr_ptr} + (IDW+1)'(gi);
      assign wrapped = (sum >= (IDW+1)'(NUM_REQ)) ? sum - (IDW+1)'(NUM_REQ) : sum;
      assign cand[gi] = wrapped[IDW-1:0];
    end
  endgenerate

  // Scan from the farthest candidate down so the nearest hit overwrites.
  always_comb begin
    win_idx    = '0;
    win_any    = 1'b0;
    win_onehot = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[cand[i]]) begin
        win_idx = cand[i];
        win_any = 1'b1;
      end
    end
    win_onehot[win_idx] = win_any;
  end

endmodule

// File: rtl/hier_include_nested_credit_arb.sv
// Round-robin arbiter handing out nested-top buffer pool credits; each capture
// reserves a credit and is forwarded as a registered grant id.
module hier_include_nested_credit_arb
  import hierIncludeNestedTop_package::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input logic clk,
  input logic rst_n,
  hier_include_nested_credit_arb_if.master bus
);

  arbStateT           state_reg, state_next;
  logic [IDW-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [IDW-1:0]     out_id_reg, out_id_next;
  creditT             credits_reg, credits_next;
  logic               err_reg, err_next;
  logic               capture;
  logic [NUM_REQ-1:0] win_onehot;
  logic [IDW-1:0]     win_idx;
  logic               win_any;

  hier_include_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req        (bus.req_valid),
    .rr_ptr     (rr_ptr_reg),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .win_any    (win_any)
  );

  // Arbitration only looks at the registered credit count, so a release cannot
  // enable a capture in the same cycle.
  assign capture = rst_n && (state_reg == IDLE) && win_any && (credits_reg != '0);

  always_comb begin
    state_next   = state_reg;
    rr_ptr_next  = rr_ptr_reg;
    out_id_next  = out_id_reg;
    credits_next = credits_reg;
    err_next     = err_reg;

    case (state_reg)
      IDLE: begin
        if (capture) begin
          state_next  = HOLD;
          out_id_next = win_idx;
          rr_ptr_next = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + IDW'(1);
        end
      end
      HOLD: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    case ({capture, bus.rel_valid})
      2'b10: credits_next = credits_reg - creditT'(1);
      2'b01: begin
        if (credits_reg == creditT'(POOL_SIZE)) err_next = 1'b1;
        else credits_next = credits_reg + creditT'(1);
      end
      default: credits_next = credits_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      rr_ptr_reg  <= '0;
      out_id_reg  <= '0;
      credits_reg <= creditT'(POOL_SIZE);
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rr_ptr_reg  <= rr_ptr_next;
      out_id_reg  <= out_id_next;
      credits_reg <= credits_next;
      err_reg     <= err_next;
    end
  end

  assign bus.req_ready    = capture ? win_onehot : '0;
  assign bus.out_valid    = (state_reg == HOLD);
  assign bus.out_id       = out_id_reg;
  assign bus.credits      = credits_reg;
  assign bus.err_overflow = err_reg;

endmodule

// File: tb/tb_hier_include_nested_credit_arb.sv
// Directed bench for the credit arbiter: inputs change on negedge, outputs are
// checked 1ns later, well clear of the rising edge.
module tb_hier_include_nested_credit_arb;
  import hierIncludeNestedTop_package::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hier_include_nested_credit_arb_if #(.NUM_REQ(4)) bus ();

  hier_include_nested_credit_arb #(.NUM_REQ(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic drive(input logic [3:0] rv, input logic ordy, input logic rel);
    bus.req_valid = rv;
    bus.out_ready = ordy;
    bus.rel_valid = rel;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(4'b0000, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Stimulus only: n complete grants with out_ready high, ends at a negedge in IDLE.
  task automatic grant_n(input int n, input logic [3:0] rv);
    for (int i = 0; i < n; i++) begin
      drive(rv, 1'b1, 1'b0);
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(4'b1111, 1'b1, 1'b1);
    #1;
    checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready_forced got=%b exp=0000", bus.req_ready); end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_id !== 2'd0) begin failures++; $display("FAIL reset_out_id got=%0d exp=0", bus.out_id); end
    checks++; if (bus.credits !== creditT'(8)) begin failures++; $display("FAIL reset_credits got=%0d exp=8", bus.credits); end
    checks++; if (bus.err_overflow !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err_overflow); end
    checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready_held got=%b exp=0000", bus.req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0000, 1'b1, 1'b0);
    $display("reset: done");
  endtask

  task automatic test_single_requester();
    for (int g = 0; g < 8; g++) begin
      drive(4'b0001, 1'b1, 1'b0);
      #1;
      checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready g=%0d got=%b exp=0001", g, bus.req_ready); end
      checks++; if (bus.credits !== creditT'(8 - g)) begin failures++; $display("FAIL single_credits_pre g=%0d got=%0d exp=%0d", g, bus.credits, 8 - g); end
      @(negedge clk);
      #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd0) begin failures++; $display("FAIL single_grant g=%0d got=%b/%0d exp=1/0", g, bus.out_valid, bus.out_id); end
      checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL single_hold_ready g=%0d got=%b exp=0000", g, bus.req_ready); end
      checks++; if (bus.credits !== creditT'(7 - g)) begin failures++; $display("FAIL single_credits_post g=%0d got=%0d exp=%0d", g, bus.credits, 7 - g); end
      $display("single: grant %0d id=%0d credits=%0d", g, bus.out_id, bus.credits);
      @(negedge clk);
    end
    #1;
    checks++; if (bus.credits !== creditT'(0)) begin failures++; $display("FAIL single_empty_credits got=%0d exp=0", bus.credits); end
    checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL single_empty_ready got=%b exp=0000", bus.req_ready); end
    @(negedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin failures++; $display("FAIL single_stalled got=%b/%b exp=0/0000", bus.out_valid, bus.req_ready); end
  endtask

  task automatic test_round_robin();
    int ids [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_oh;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      exp_oh = 4'b0001 << ids[k];
      drive(4'b1111, 1'b1, 1'b1);
      #1;
      checks++; if (bus.req_ready !== exp_oh) begin failures++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, bus.req_ready, exp_oh); end
      @(negedge clk);
      drive(4'b1111, 1'b1, 1'b0);
      #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_id !== 2'(ids[k])) begin failures++; $display("FAIL rr_id k=%0d got=%b/%0d exp=1/%0d", k, bus.out_valid, bus.out_id, ids[k]); end
      checks++; if (bus.credits !== creditT'(8)) begin failures++; $display("FAIL rr_credits k=%0d got=%0d exp=8", k, bus.credits); end
      $display("rr: grant %0d id=%0d credits=%0d", k, bus.out_id, bus.credits);
      @(negedge clk);
    end
    #1;
    checks++; if (bus.err_overflow !== 1'b0) begin failures++; $display("FAIL rr_err got=%b exp=0", bus.err_overflow); end
  endtask

  task automatic test_release_at_zero();
    do_reset();
    grant_n(8, 4'b0001);
    drive(4'b0010, 1'b1, 1'b1);
    #1;
    checks++; if (bus.credits !== creditT'(0) || bus.req_ready !== 4'b0000) begin failures++; $display("FAIL zero_cycleN got=%0d/%b exp=0/0000", bus.credits, bus.req_ready); end
    @(negedge clk);
    drive(4'b0010, 1'b1, 1'b0);
    #1;
    checks++; if (bus.credits !== creditT'(1)) begin failures++; $display("FAIL zero_credit_back got=%0d exp=1", bus.credits); end
    checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL zero_ready got=%b exp=0010", bus.req_ready); end
    @(negedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd1 || bus.credits !== creditT'(0)) begin failures++; $display("FAIL zero_grant got=%b/%0d/%0d exp=1/1/0", bus.out_valid, bus.out_id, bus.credits); end
    $display("zero: release regranted id=%0d", bus.out_id);
    drive(4'b0000, 1'b1, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_capture_and_release();
    do_reset();
    grant_n(3, 4'b0001);
    drive(4'b0001, 1'b1, 1'b1);
    #1;
    checks++; if (bus.req_ready !== 4'b0001 || bus.credits !== creditT'(5)) begin failures++; $display("FAIL both_pre got=%b/%0d exp=0001/5", bus.req_ready, bus.credits); end
    @(negedge clk);
    drive(4'b0000, 1'b1, 1'b0);
    #1;
    checks++; if (bus.credits !== creditT'(5)) begin failures++; $display("FAIL both_credits got=%0d exp=5", bus.credits); end
    checks++; if (bus.err_overflow !== 1'b0 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL both_err_valid got=%b/%b exp=0/1", bus.err_overflow, bus.out_valid); end
    $display("both: credits=%0d", bus.credits);
    @(negedge clk);
  endtask

  task automatic test_overflow();
    do_reset();
    drive(4'b0000, 1'b1, 1'b1);
    #1;
    checks++; if (bus.err_overflow !== 1'b0) begin failures++; $display("FAIL ovf_pre got=%b exp=0", bus.err_overflow); end
    @(negedge clk);
    drive(4'b0000, 1'b1, 1'b0);
    #1;
    checks++; if (bus.credits !== creditT'(8) || bus.err_overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0d/%b exp=8/1", bus.credits, bus.err_overflow); end
    grant_n(1, 4'b0001);
    #1;
    checks++; if (bus.err_overflow !== 1'b1 || bus.credits !== creditT'(7)) begin failures++; $display("FAIL ovf_sticky got=%b/%0d exp=1/7", bus.err_overflow, bus.credits); end
    do_reset();
    #1;
    checks++; if (bus.err_overflow !== 1'b0 || bus.credits !== creditT'(8)) begin failures++; $display("FAIL ovf_clear got=%b/%0d exp=0/8", bus.err_overflow, bus.credits); end
    $display("overflow: sticky flag cleared by reset");
  endtask

  task automatic test_stall_then_reset();
    do_reset();
    drive(4'b0100, 1'b0, 1'b0);
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL stall_ready got=%b exp=0100", bus.req_ready); end
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd2) begin failures++; $display("FAIL stall_hold c=%0d got=%b/%0d exp=1/2", c, bus.out_valid, bus.out_id); end
      checks++; if (bus.req_ready !== 4'b0000 || bus.credits !== creditT'(7)) begin failures++; $display("FAIL stall_state c=%0d got=%b/%0d exp=0000/7", c, bus.req_ready, bus.credits); end
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1111, 1'b1, 1'b0);
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_id !== 2'd0 || bus.credits !== creditT'(8)) begin failures++; $display("FAIL stall_reset got=%b/%0d/%0d exp=0/0/8", bus.out_valid, bus.out_id, bus.credits); end
    checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL stall_ptr got=%b exp=0001", bus.req_ready); end
    $display("stall: reset dropped grant, credits=%0d", bus.credits);
    @(negedge clk);
    drive(4'b0000, 1'b1, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    drive(4'b0000, 1'b1, 1'b0);
    test_reset();
    test_single_requester();
    test_round_robin();
    test_release_at_zero();
    test_capture_and_release();
    test_overflow();
    test_stall_then_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
